// File: rtl/truncate_phase_controller_pkg.sv
// Shared constants and state encoding for the cluster-truncation phase controller.
// Frame geometry defaults are also used by the truncation datapath.
package truncate_phase_controller_pkg;

  localparam int FRAME_LEN_DEF  = 8;
  localparam int PHASE_BITS_DEF = 3;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/truncate_phase_controller_sat_counter.sv
// Saturating event counter for slow control; a clear wins over a simultaneous increment.
module sat_counter
  import truncate_phase_controller_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/truncate_phase_controller.sv
// Locks the truncation phase counter to the bunch-crossing strobe, drives the
// datapath load/phase, and tracks frame alignment and cluster overflow.
module truncate_phase_controller
  import truncate_phase_controller_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int PHASE_BITS = PHASE_BITS_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  global_reset,
  input  logic                  bx_strobe,
  input  logic [3:0]            delay,
  input  logic                  remaining,
  input  logic                  cnt_reset,
  output logic [PHASE_BITS-1:0] phase,
  output logic                  load,
  output logic                  synced,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  overflow_cnt,
  output logic [CNT_WIDTH-1:0]  sync_err_cnt
);

  // gap must be able to hold FRAME_LEN itself to flag a missing strobe
  localparam int GAP_W = PHASE_BITS + 1;
  localparam logic [GAP_W-1:0]      GAP_SAT    = GAP_W'(FRAME_LEN);
  localparam logic [GAP_W-1:0]      GAP_LAST   = GAP_W'(FRAME_LEN - 1);
  localparam logic [PHASE_BITS-1:0] PHASE_LAST = PHASE_BITS'(FRAME_LEN - 1);

  state_t                state_q, state_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic                  load_q, load_d;
  logic                  synced_q, synced_d;
  logic                  ovf_q, ovf_d;
  logic [3:0]            dly_q, dly_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  err_d;
  logic                  on_time;

  always_comb begin
    state_d = state_q;
    phase_d = '0;
    load_d  = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    dly_d   = dly_q;
    gap_d   = bx_strobe ? '0 : ((gap_q == GAP_SAT) ? gap_q : gap_q + 1'b1);
    on_time = bx_strobe && (gap_q == GAP_LAST);

    case (state_q)
      IDLE: begin
        if (bx_strobe) begin
          dly_d   = delay;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        // a fresh strobe re-arms the delay so the lock follows the latest frame
        if (bx_strobe) begin
          dly_d = delay;
        end else if (dly_q == 4'd0) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      RUN: begin
        ovf_d = (phase_q == PHASE_LAST) && remaining;
        if (bx_strobe && !on_time) begin
          err_d   = 1'b1;
          dly_d   = delay;
          state_d = ALIGN;
        end else if (gap_q == GAP_SAT) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + 1'b1;
          load_d  = (phase_q == PHASE_LAST);
        end
      end
      default: state_d = IDLE;
    endcase

    synced_d = (state_d == RUN);
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      load_q   <= 1'b0;
      synced_q <= 1'b0;
      ovf_q    <= 1'b0;
      dly_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      load_q   <= load_d;
      synced_q <= synced_d;
      ovf_q    <= ovf_d;
      dly_q    <= dly_d;
      gap_q    <= gap_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_ovf_cnt (
    .clk_i (clock),
    .rst_i (global_reset),
    .inc_i (ovf_d),
    .clr_i (cnt_reset),
    .cnt_o (overflow_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk_i (clock),
    .rst_i (global_reset),
    .inc_i (err_d),
    .clr_i (cnt_reset),
    .cnt_o (sync_err_cnt)
  );

  assign phase    = phase_q;
  assign load     = load_q;
  assign synced   = synced_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_truncate_phase_controller.sv
// Scoreboard bench: expected load/overflow cycles are queued as strobes and
// remaining flags are driven, then matched against observed DUT pulses.
module tb_truncate_phase_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        global_reset, bx_strobe, remaining, cnt_reset, cnt_reset2;
  logic [3:0]  delay;
  logic [2:0]  phase, phase2;
  logic        load, synced, overflow, load2, synced2, overflow2;
  logic [15:0] overflow_cnt, sync_err_cnt;
  logic [1:0]  ovf_cnt2, err_cnt2;

  truncate_phase_controller u_dut (
    .clock        (clock),
    .global_reset (global_reset),
    .bx_strobe    (bx_strobe),
    .delay        (delay),
    .remaining    (remaining),
    .cnt_reset    (cnt_reset),
    .phase        (phase),
    .load         (load),
    .synced       (synced),
    .overflow     (overflow),
    .overflow_cnt (overflow_cnt),
    .sync_err_cnt (sync_err_cnt)
  );

  // narrow-counter instance, never cleared, to observe saturation
  truncate_phase_controller #(.CNT_WIDTH(2)) u_dut2 (
    .clock        (clock),
    .global_reset (global_reset),
    .bx_strobe    (bx_strobe),
    .delay        (delay),
    .remaining    (remaining),
    .cnt_reset    (cnt_reset2),
    .phase        (phase2),
    .load         (load2),
    .synced       (synced2),
    .overflow     (overflow2),
    .overflow_cnt (ovf_cnt2),
    .sync_err_cnt (err_cnt2)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_load_q[$];
  int exp_ovf_q[$];
  int last_load = 0;
  bit mon_en = 1'b0;

  bit         strb [200];
  bit         rem  [200];
  bit         crst [200];
  bit         ph7  [200];
  logic [3:0] dlyv [200];

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // delay value the lock was acquired with: 0 for the first run, 5 after relock from IDLE
  function automatic int lockd(input int c);
    return (c < 66) ? 0 : 5;
  endfunction

  always @(negedge clock) begin
    if (mon_en) begin
      while (exp_load_q.size() > 0 && exp_load_q[0] < cyc) begin
        chk("load_missed", 0, exp_load_q[0]);
        void'(exp_load_q.pop_front());
      end
      if (load) begin
        if (exp_load_q.size() > 0) begin
          int e;
          e = exp_load_q.pop_front();
          chk("load_cycle", cyc, e);
          last_load = e;
        end else begin
          chk("load_unexpected", cyc, 0);
        end
      end
      if (synced) chk("phase", int'(phase), (cyc - last_load) % 8);

      while (exp_ovf_q.size() > 0 && exp_ovf_q[0] < cyc) begin
        chk("ovf_missed", 0, exp_ovf_q[0]);
        void'(exp_ovf_q.pop_front());
      end
      if (overflow) begin
        if (exp_ovf_q.size() > 0) chk("ovf_cycle", cyc, exp_ovf_q.pop_front());
        else chk("ovf_unexpected", cyc, 0);
      end
    end
  end

  initial begin
    int strobes[$] = '{10, 18, 26, 31, 39, 47, 55, 70, 78, 86, 94, 102, 110, 118};
    int rems[$]    = '{84, 88, 92, 100, 108, 116};
    global_reset = 1'b1;
    bx_strobe    = 1'b0;
    remaining    = 1'b0;
    cnt_reset    = 1'b0;
    cnt_reset2   = 1'b0;
    delay        = 4'd0;

    foreach (strobes[i]) begin
      strb[strobes[i]] = 1'b1;
      if (strobes[i] < 118) ph7[strobes[i] + 2 + lockd(strobes[i]) + 7] = 1'b1;
    end
    foreach (rems[i]) rem[rems[i]] = 1'b1;
    for (int c = 66; c <= 76; c++) rem[c] = 1'b1;
    crst[108] = 1'b1;
    for (int c = 0; c < 200; c++) dlyv[c] = (c < 66) ? 4'd0 : ((c < 80) ? 4'd5 : 4'd2);

    while (cyc < 2) @(negedge clock);
    chk("rst_phase", int'(phase), 0);
    chk("rst_load", int'(load), 0);
    chk("rst_synced", int'(synced), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_ovf_cnt", int'(overflow_cnt), 0);
    chk("rst_err_cnt", int'(sync_err_cnt), 0);

    while (cyc < 120) begin
      int c;
      c = cyc;
      if (c == 3) begin
        global_reset = 1'b0;
        mon_en       = 1'b1;
      end
      bx_strobe = strb[c];
      remaining = rem[c];
      cnt_reset = crst[c];
      delay     = dlyv[c];
      if (strb[c] && c < 118) exp_load_q.push_back(c + 2 + lockd(c));
      if (rem[c] && ph7[c]) exp_ovf_q.push_back(c + 1);
      case (c)
        11:  chk("synced_in_align", int'(synced), 0);
        12:  chk("synced_locked", int'(synced), 1);
        30:  chk("err_cnt_clean", int'(sync_err_cnt), 0);
        32: begin
          chk("err_cnt_early", int'(sync_err_cnt), 1);
          chk("synced_drop_early", int'(synced), 0);
        end
        60: begin
          chk("err_cnt_relocked", int'(sync_err_cnt), 1);
          chk("synced_relocked", int'(synced), 1);
        end
        65: begin
          chk("err_cnt_missing", int'(sync_err_cnt), 2);
          chk("synced_drop_missing", int'(synced), 0);
        end
        66:  chk("phase_idle", int'(phase), 0);
        76:  chk("synced_align_d5", int'(synced), 0);
        77:  chk("synced_lock_d5", int'(synced), 1);
        100: chk("err_cnt_stable", int'(sync_err_cnt), 2);
        102: begin
          chk("ovf_cnt_3", int'(overflow_cnt), 3);
          chk("ovf_cnt2_3", int'(ovf_cnt2), 3);
        end
        109: begin
          chk("ovf_cnt_clr_prio", int'(overflow_cnt), 0);
          chk("ovf_cnt2_sat4", int'(ovf_cnt2), 3);
        end
        118: begin
          chk("ovf_cnt_after_clr", int'(overflow_cnt), 1);
          chk("ovf_cnt2_sat5", int'(ovf_cnt2), 3);
        end
        default: ;
      endcase
      @(negedge clock);
    end

    mon_en    = 1'b0;
    bx_strobe = 1'b0;
    remaining = 1'b0;
    #2 global_reset = 1'b1;
    #1;
    chk("arst_phase", int'(phase), 0);
    chk("arst_load", int'(load), 0);
    chk("arst_synced", int'(synced), 0);
    chk("arst_overflow", int'(overflow), 0);
    chk("arst_ovf_cnt", int'(overflow_cnt), 0);
    chk("arst_err_cnt", int'(sync_err_cnt), 0);
    chk("arst2_phase", int'(phase2), 0);
    chk("arst2_load", int'(load2), 0);
    chk("arst2_synced", int'(synced2), 0);
    chk("arst2_overflow", int'(overflow2), 0);
    chk("arst2_ovf_cnt", int'(ovf_cnt2), 0);
    chk("arst2_err_cnt", int'(err_cnt2), 0);
    @(negedge clock);
    @(negedge clock);

    while (exp_load_q.size() > 0) chk("load_never_seen", 0, exp_load_q.pop_front());
    while (exp_ovf_q.size() > 0) chk("ovf_never_seen", 0, exp_ovf_q.pop_front());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truncate_phase_controller.md
Name: truncate_phase_controller

Overview:
Sequences the iterative cluster-truncation datapath. Locks a phase counter to the per-frame bunch-crossing strobe with a programmable delay. Drives the datapath load strobe and phase, and monitors frame alignment. Flags frames where clusters remain after the last extraction phase, and keeps saturating error and overflow counters for slow control. Sits between the trigger/TTC clock-domain logic and the truncation stage, one instance per truncation stage.

Parameters:
FRAME_LEN, 8, clocks per frame (number of truncation phases); power of two, 2..16.
PHASE_BITS, 3, width of phase output; equals log2(FRAME_LEN).
CNT_WIDTH, 16, width of the saturating overflow and sync-error counters.

Ports:
clock  in  1  fabric clock.
global_reset  in  1  asynchronous, active-high reset.
bx_strobe  in  1  one-cycle pulse, nominally every FRAME_LEN clocks.
delay  in  4  cycles between strobe and datapath load; sampled only on entry to ALIGN.
remaining  in  1  OR of all datapath segment registers; high means clusters are still present.
cnt_reset  in  1  synchronous clear of both counters.
phase  out  PHASE_BITS  current truncation phase.
load  out  1  registered; high when phase==0 in RUN. The datapath latches a new frame on this cycle.
synced  out  1  high while in RUN.
overflow  out  1  one-cycle pulse: frame truncated (clusters lost).
overflow_cnt  out  CNT_WIDTH  saturating count of overflow pulses.
sync_err_cnt  out  CNT_WIDTH  saturating count of alignment errors.

Behaviour:
- Async reset values: state=IDLE, phase=0, load=0, synced=0, overflow=0, both counters=0, dly_cnt=0, gap=0. Reset mid-operation takes effect immediately, with no partial frame completion.
- gap counter runs in every state:
  - cleared on a cycle with bx_strobe=1;
  - otherwise increments, saturating at FRAME_LEN.
  - A strobe is "on time" iff gap==FRAME_LEN-1 in its cycle.
- IDLE: load=0, phase held at 0. On bx_strobe: dly_cnt<=delay, go to ALIGN.
- ALIGN:
  - If dly_cnt==0: go to RUN with phase<=0 and load<=1.
  - Else dly_cnt decrements.
  - A strobe arriving during ALIGN restarts ALIGN (dly_cnt<=delay) and counts no error.
  - Latency: a strobe in cycle k gives first load=1 in cycle k+delay+2.
- RUN:
  - phase<=phase+1 mod FRAME_LEN every cycle.
  - load registered high exactly when the next phase is 0.
  - synced=1.
- Alignment errors in RUN:
  - Strobe with gap!=FRAME_LEN-1 (early or late): sync_err_cnt++, synced drops the next cycle, dly_cnt<=delay, go to ALIGN. The system relocks to the new strobe with the same k+delay+2 latency.
  - gap reaching FRAME_LEN with no strobe (missing strobe): sync_err_cnt++, go to IDLE.
  - Both cases in one cycle count once.
- Overflow:
  - In RUN, with phase==FRAME_LEN-1 and remaining==1: overflow=1 in the next cycle, and overflow_cnt++.
  - Overflow is not evaluated in IDLE or ALIGN.
- Counters:
  - Saturate at all-ones with no wrap.
  - cnt_reset takes priority over a simultaneous increment (result 0).
- delay changes while in RUN do not affect phase until the next realign.
- All outputs are registered.

Decomposition:
- Shared package holds:
  - FRAME_LEN and PHASE_BITS defaults, shared with the truncation datapath;
  - state encoding constants IDLE=2'd0, ALIGN=2'd1, RUN=2'd2;
  - CNT_WIDTH default.
- One natural sub-module: sat_counter (parameterised width; inc, clr with clr priority, async reset). It is instantiated twice.
- FSM, gap tracker and phase counter stay in the top level.

Test Plan:
1. Reset; delay=0; strobes at cycles 10,18,26,… → load first high at cycle 12 and every 8 cycles after; phase 0..7 repeating; synced=1 from cycle 12; sync_err_cnt=0.
2. delay=5; strobe at cycle 10 → load high at cycle 17; change delay to 2 while in RUN → load timing unchanged.
3. Locked at delay=0, then strobe arrives 3 cycles early at cycle 31 → sync_err_cnt=1, synced low, load relocks at cycle 33, then every 8 cycles with no further errors.
4. Locked, then one strobe omitted → sync_err_cnt=1, state IDLE, synced=0, load stays low until the next strobe plus 2 cycles.
5. remaining=1 at phase 7 for 3 consecutive frames → 3 overflow pulses, each 1 cycle after phase 7; overflow_cnt=3. Then cnt_reset coincident with a 4th overflow → overflow_cnt=0.
6. CNT_WIDTH=2 with 5 overflows → overflow_cnt holds 3. Assert global_reset mid-RUN → phase, load, synced and counters read 0 before the next clock edge.
